uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter SHIFT, default 4, meaning log2 of clocks per bit period (bit period = 2^SHIFT clk cycles); legal range 1..8.
REQ-002 The module SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits checked per frame; legal range 1..2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The module SHALL have port dout, output, 8 bits: last correctly framed received byte.
REQ-007 The module SHALL have port rx_valid, output, 1 bit: dout holds an unacknowledged byte (level).
REQ-008 The module SHALL have port rx_ack, input, 1 bit: consumer acknowledge; clears rx_valid.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 The module SHALL have port overrun, output, 1 bit: one-cycle pulse when an unacknowledged byte is overwritten.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs; input-to-rxs latency is 2 cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK; a SHIFT-bit cycle counter; a 3-bit bit index; an 8-bit shift register.
REQ-013 IDLE: when rxs==0, go to START with the counter at 0; otherwise stay.
REQ-014 START: when counter==2^(SHIFT-1)-1 (mid start bit), sample rxs; if 1 (glitch), return to IDLE; if 0, go to DATA with counter=0 and bit index=0.
REQ-015 DATA: when counter==2^SHIFT-1, shift rxs into the shift register LSB-first (shift right, new bit into bit 7), clear the counter, and increment the bit index; after the 8th sample, go to STOP.
REQ-016 STOP: sample rxs each time counter==2^SHIFT-1, STOP_BITS samples in total; a 0 sample SHALL pulse frame_err for one cycle, leave dout and rx_valid unchanged, and go to BREAK.
REQ-017 When the last stop sample is 1, on that same edge dout SHALL load the shift register, rx_valid SHALL be set, and the FSM SHALL return to IDLE (mid stop bit, so it resynchronizes on the next falling edge).
REQ-018 BREAK: stay until rxs==1, then go to IDLE; no frame_err repeats while the line stays low.
REQ-019 rx_valid SHALL clear on the edge where rx_ack==1 and no byte completes; rx_ack while rx_valid==0 SHALL have no effect.
REQ-020 If a byte completes while rx_valid==1 and rx_ack==0, dout SHALL be overwritten, rx_valid SHALL stay 1, and overrun SHALL pulse for one cycle.
REQ-021 If a byte completes in the same cycle that rx_ack==1, dout SHALL take the new byte, rx_valid SHALL stay 1, and there SHALL be no overrun.
REQ-022 Latency SHALL be: rx_valid rises 2 + (2^(SHIFT-1)) + (8+STOP_BITS)*2^SHIFT cycles after the rx falling edge (within synchronizer uncertainty ±1).
REQ-023 The counter SHALL wrap modulo 2^SHIFT with no separate terminal flag.

Reset
REQ-024 With rst_n low, the FSM SHALL be in IDLE, the synchronizer flops at 1, and the counter, bit index and shift register at 0.
REQ-025 With rst_n low, dout=8'h00, rx_valid=0, frame_err=0 and overrun=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_valid, frame_err or overrun pulse; after release, reception SHALL resume only on a fresh falling edge of rxs.

Verification (SHIFT=2, STOP_BITS=1 unless noted)
REQ-027 Drive the frame 0,1,0,1,0,1,0,1,0,1 (start, 8'h55 LSB-first, stop) at 4 clk/bit -> dout=8'h55, rx_valid=1 held until rx_ack, frame_err=0, overrun=0.
REQ-028 Send two bytes 8'hA3 then 8'h3C back-to-back without rx_ack -> after the second byte dout=8'h3C, one overrun pulse, rx_valid=1.
REQ-029 Send 8'hF0 with stop bit 0, then hold rx low for 40 cycles, then release -> exactly one frame_err pulse, dout unchanged, FSM in IDLE after rx is high; a following 8'h12 is received correctly.
REQ-030 Apply a 1-cycle low glitch on idle rx -> no state beyond START, no output change.
REQ-031 Assert rst_n=0 during bit 4 of 8'hFF, then release and send 8'h81 -> all outputs at reset values during reset, then dout=8'h81 with rx_valid=1.
REQ-032 STOP_BITS=2: second stop bit 0 -> frame_err pulse; rx_ack asserted on the same cycle a byte completes -> rx_valid=1 with no overrun.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling driven by a
// free-running SHIFT-bit counter, 8 data bits LSB-first, STOP_BITS stop bits.
//
// Handshake: rx_valid is a level meaning "dout holds a byte the consumer has
// not yet taken". The consumer takes it by holding rx_ack high for one cycle
// while rx_valid is high. rx_ack while rx_valid is low does nothing. A byte
// completing in the same cycle as rx_ack replaces dout and keeps rx_valid
// high with no overrun. A byte completing while rx_valid is high and rx_ack
// is low replaces dout and pulses overrun for one cycle.
//
// state_dbg exposes the FSM state: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4.
module uart_rx #(
  parameter int SHIFT     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Counter value at the middle of the start bit and at the end of a full bit.
  localparam logic [SHIFT-1:0] CNT_HALF  = SHIFT'((1 << (SHIFT - 1)) - 1);
  localparam logic [SHIFT-1:0] CNT_LAST  = '1;
  localparam logic [SHIFT-1:0] CNT_ONE   = SHIFT'(1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  logic             rx_meta;
  logic             rxs;
  state_t           state, state_d;
  logic [SHIFT-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shreg, sh_d;
  logic             stop_idx, stop_d;
  logic             byte_done;
  logic             stop_bad;

  assign state_dbg = state;

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // FSM state, bit counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      stop_idx <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      shreg    <= sh_d;
      stop_idx <= stop_d;
    end
  end

  // Next-state logic; the counter wraps naturally at the end of each bit.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_ONE;
    bit_d     = bit_idx;
    sh_d      = shreg;
    stop_d    = stop_idx;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          // Re-phase the counter so later samples land mid-bit.
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          sh_d  = {rxs, shreg[7:1]};
          bit_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            stop_d  = 1'b0;
          end
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          if (!rxs) begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end else if (stop_idx == STOP_LAST) begin
            // Return mid stop bit so the next start edge is caught promptly.
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_d = stop_idx + 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output byte, valid level and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (byte_done) begin
        dout     <= shreg;
        rx_valid <= 1'b1;
        overrun  <= rx_valid && !rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (SHIFT=2 with one and with two stop
// bits) share clock and reset. Frames are built from bytes by the bench, the
// expected outcome of each frame is pushed into a per-instance queue, and a
// monitor pops and compares whenever an instance presents a byte or an error.
module tb_uart_rx;

  localparam int F = 4;          // clocks per bit
  localparam int H = 2;          // clocks to mid start bit
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rx_l, rx_ack_l, rx_valid_l, frame_err_l, overrun_l;
  logic [7:0] dout_l [2];
  logic [2:0] st_l [2];

  uart_rx #(.SHIFT(2), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .dout(dout_l[0]),
    .rx_valid(rx_valid_l[0]), .rx_ack(rx_ack_l[0]),
    .frame_err(frame_err_l[0]), .overrun(overrun_l[0]), .state_dbg(st_l[0])
  );

  uart_rx #(.SHIFT(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .dout(dout_l[1]),
    .rx_valid(rx_valid_l[1]), .rx_ack(rx_ack_l[1]),
    .frame_err(frame_err_l[1]), .overrun(overrun_l[1]), .state_dbg(st_l[1])
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Expected events: {is_frame_err, overrun, dout}.
  logic [9:0] exp_q0 [$];
  logic [9:0] exp_q1 [$];
  logic       model_v [2];
  logic [7:0] model_d [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int k, input logic [9:0] e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_v[k] = 1'b0;
      model_d[k] = 8'h00;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Reference model: a frame is good iff every stop bit is 1. A good frame
  // delivers its byte; it overruns iff a byte is pending and not acked in
  // the completion cycle. A bad frame only reports an error.
  task automatic expect_frame(input int k, input logic [7:0] b, input logic [1:0] stop_pat,
                              input logic ack_same);
    int  nstop;
    logic bad;
    nstop = (k == 0) ? 1 : 2;
    bad = 1'b0;
    for (int s = 0; s < nstop; s++) if (!stop_pat[s]) bad = 1'b1;
    if (bad) begin
      push_exp(k, {1'b1, 1'b0, model_d[k]});
    end else begin
      push_exp(k, {1'b0, model_v[k] && !ack_same, b});
      model_v[k] = 1'b1;
      model_d[k] = b;
    end
  endtask

  // Drive one frame; on a bad stop bit, keep the line low hold_low cycles.
  task automatic send_frame(input int k, input logic [7:0] b, input logic [1:0] stop_pat,
                            input int hold_low, input int gap_bits,
                            input logic ack_same, input logic do_expect);
    int  nstop;
    logic bad;
    nstop = (k == 0) ? 1 : 2;
    bad = 1'b0;
    for (int s = 0; s < nstop; s++) if (!stop_pat[s]) bad = 1'b1;
    if (do_expect) expect_frame(k, b, stop_pat, ack_same);
    @(negedge clk);
    rx_l[k] = 1'b0;
    repeat (F) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_l[k] = b[i];
      repeat (F) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      rx_l[k] = stop_pat[s];
      repeat (F) @(negedge clk);
    end
    if (bad) begin
      rx_l[k] = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rx_l[k] = 1'b1;
    repeat (gap_bits * F) @(negedge clk);
  endtask

  task automatic ack_pulse(input int k);
    @(negedge clk);
    rx_ack_l[k] = 1'b1;
    @(negedge clk);
    rx_ack_l[k] = 1'b0;
    model_v[k] = 1'b0;
  endtask

  // Monitor: a byte event is rx_valid rising, an overrun, or a new dout
  // while valid; an error event is a frame_err pulse.
  logic       prev_v [2];
  logic [7:0] prev_d [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_v[k] = 1'b0;
        prev_d[k] = 8'h00;
      end else begin
        logic ev_b;
        logic [9:0] act;
        logic [9:0] e;
        ev_b = rx_valid_l[k] && (!prev_v[k] || overrun_l[k] || dout_l[k] != prev_d[k]);
        act  = {frame_err_l[k], overrun_l[k], dout_l[k]};
        if (ev_b || frame_err_l[k]) begin
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_event actual=%0h required=none", k, act);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("dut%0d_event", k), {22'd0, act}, {22'd0, e});
          end
        end
        prev_v[k] = rx_valid_l[k];
        prev_d[k] = dout_l[k];
      end
    end
  end

  task automatic check_outputs(input int k, input string tag, input logic [7:0] d, input logic v);
    check($sformatf("%s_dut%0d_dout", tag, k), {24'd0, dout_l[k]}, {24'd0, d});
    check($sformatf("%s_dut%0d_valid", tag, k), {31'd0, rx_valid_l[k]}, {31'd0, v});
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_outputs(k, tag, 8'h00, 1'b0);
      check($sformatf("%s_dut%0d_ferr", tag, k), {31'd0, frame_err_l[k]}, 32'd0);
      check($sformatf("%s_dut%0d_ovr", tag, k), {31'd0, overrun_l[k]}, 32'd0);
      check($sformatf("%s_dut%0d_state", tag, k), {29'd0, st_l[k]}, {29'd0, ST_IDLE});
    end
  endtask

  // Stimulus.
  initial begin
    int n;
    int lat;
    logic [2:0] maxs;
    rst_n    = 1'b0;
    rx_l     = 2'b11;
    rx_ack_l = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x55 with latency measurement from the falling edge of rx.
    lat = 2 + H + (8 + 1) * F;
    n = 0;
    fork
      send_frame(0, 8'h55, 2'b11, 0, 1, 1'b0, 1'b1);
      begin
        @(negedge clk);
        while (!rx_valid_l[0] && n < 200) begin
          @(posedge clk);
          n++;
          #1;
        end
      end
    join
    check("latency_55", {31'd0, (n >= lat - 1 && n <= lat + 1)}, 32'd1);
    repeat (20) @(negedge clk);
    check_outputs(0, "held_55", 8'h55, 1'b1);
    ack_pulse(0);
    @(negedge clk);
    check_outputs(0, "acked_55", 8'h55, 1'b0);
    ack_pulse(0);
    @(negedge clk);
    check_outputs(0, "ack_idle", 8'h55, 1'b0);

    // Back-to-back without ack: overrun on the second byte.
    send_frame(0, 8'hA3, 2'b11, 0, 0, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 2'b11, 0, 1, 1'b0, 1'b1);
    check_outputs(0, "overrun", 8'h3C, 1'b1);
    ack_pulse(0);

    // Bad stop bit, line held low, then a good byte.
    send_frame(0, 8'hF0, 2'b00, 40, 1, 1'b0, 1'b1);
    check($sformatf("break_idle_state"), {29'd0, st_l[0]}, {29'd0, ST_IDLE});
    check_outputs(0, "after_ferr", 8'h3C, 1'b0);
    send_frame(0, 8'h12, 2'b11, 0, 1, 1'b0, 1'b1);
    check_outputs(0, "after_break", 8'h12, 1'b1);
    ack_pulse(0);

    // One-cycle glitch on the idle line.
    maxs = ST_IDLE;
    @(negedge clk);
    rx_l[0] = 1'b0;
    @(negedge clk);
    rx_l[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (st_l[0] > maxs) maxs = st_l[0];
    end
    check("glitch_max_state", {29'd0, maxs}, {29'd0, ST_START});
    check_outputs(0, "glitch", 8'h12, 1'b0);

    // Reset during data bit 4 of 0xFF, then 0x81.
    fork
      send_frame(0, 8'hFF, 2'b11, 0, 1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        repeat (5 * F + 2) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("midframe_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("post_reset_state", {29'd0, st_l[0]}, {29'd0, ST_IDLE});
    send_frame(0, 8'h81, 2'b11, 0, 1, 1'b0, 1'b1);
    check_outputs(0, "after_reset", 8'h81, 1'b1);
    ack_pulse(0);

    // Two stop bits: good byte, bad second stop, overrun, ack in completion cycle.
    send_frame(1, 8'h5A, 2'b11, 0, 1, 1'b0, 1'b1);
    send_frame(1, 8'h99, 2'b01, 10, 1, 1'b0, 1'b1);
    check_outputs(1, "stop2_err", 8'h5A, 1'b1);
    send_frame(1, 8'hC4, 2'b11, 0, 1, 1'b0, 1'b1);
    fork
      send_frame(1, 8'h7E, 2'b11, 0, 1, 1'b1, 1'b1);
      begin
        // Completion edge: spec latency plus the synchronizer cycle seen
        // from a falling edge driven half a cycle before a rising edge.
        @(negedge clk);
        repeat (2 + H + (8 + 2) * F) @(posedge clk);
        @(negedge clk);
        rx_ack_l[1] = 1'b1;
        @(negedge clk);
        rx_ack_l[1] = 1'b0;
      end
    join
    check_outputs(1, "ack_same", 8'h7E, 1'b1);

    // Randomized frames on both instances.
    for (int i = 0; i < 40; i++) begin
      int k;
      logic bad;
      logic [1:0] sp;
      k   = $urandom_range(0, 1);
      bad = ($urandom_range(0, 7) == 0);
      if (!bad)        sp = 2'b11;
      else if (k == 0) sp = 2'b10;
      else             sp = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b01;
      send_frame(k, 8'($urandom_range(0, 255)), sp,
                 bad ? $urandom_range(0, 20) : 0,
                 bad ? $urandom_range(1, 3) : $urandom_range(0, 3), 1'b0, 1'b1);
      if ($urandom_range(0, 1) != 0) ack_pulse(k);
    end

    repeat (20) @(negedge clk);
    check("dut0_queue_empty", exp_q0.size(), 32'd0);
    check("dut1_queue_empty", exp_q1.size(), 32'd0);
    for (int k = 0; k < 2; k++) check_outputs(k, "final", model_d[k], model_v[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
